asteroid_speed_ramp: RTL and testbench
======================================

// Module: asteroid_speed_ramp
// PURPOSE
//   Difficulty controller feeding the speed_level input of the game clock setter.
//   Counts asteroid kills and elapsed play time, then raises speed_level by one
//   when either threshold is reached. It saturates at MAX_LEVEL.
//   Tracks the IDLE/RUN/PAUSE/OVER play state so that the level freezes on pause
//   and on game over.
// PARAMETERS
//   MAX_LEVEL          10          top speed_level value, range 1..15
//   KILLS_PER_LEVEL    8           kills in the current level that trigger a level-up
//   SECONDS_PER_LEVEL  30          play seconds in the current level that trigger a level-up
//   TICKS_PER_SEC      50_000_000  CLOCK_50 cycles per one-second strobe
// PORTS
//   CLOCK_50      in   1  system clock, 50 MHz
//   resetn        in   1  asynchronous, active-low reset
//   start         in   1  1-cycle pulse: begin a new game
//   pause         in   1  level: hold the game while high
//   game_over     in   1  1-cycle pulse: player died
//   kill          in   1  1-cycle pulse: one asteroid destroyed
//   speed_level   out  4  current difficulty, 0..MAX_LEVEL, feeds the game clock setter
//   level_up      out  1  1-cycle pulse on every increment of speed_level
//   playing       out  1  high in RUN only
// BEHAVIOUR
//   Reset (resetn=0, asynchronous)
//     - state=IDLE, speed_level=0, level_up=0, playing=0.
//     - Prescaler, sec_cnt and kill_cnt all cleared.
//     - Reset takes effect at any time, including mid-game.
//   States and transitions
//     - IDLE: start -> RUN.
//     - RUN: game_over -> OVER; else pause=1 -> PAUSE.
//     - PAUSE: game_over -> OVER; else pause=0 -> RUN.
//     - OVER: start -> RUN.
//     - start is ignored in RUN and PAUSE.
//   Entering RUN from IDLE or OVER
//     - speed_level=0; prescaler, sec_cnt and kill_cnt cleared.
//   RUN, prescaler and counters
//     - Prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0.
//     - On the wrap cycle a one-second strobe fires and sec_cnt increments.
//     - kill=1 increments kill_cnt.
//   RUN, level-up
//     - Level-up condition: (kill_cnt+kill == KILLS_PER_LEVEL) or
//       (sec_cnt+strobe == SECONDS_PER_LEVEL), evaluated combinationally.
//     - On the next edge: speed_level+1, level_up=1 for exactly that cycle,
//       and sec_cnt and kill_cnt cleared to 0.
//     - Latency is one cycle from the triggering kill or strobe.
//     - The prescaler is never cleared by a level-up.
//   Simultaneous events
//     - Kill and second thresholds in the same cycle give a single increment
//       and a single pulse.
//     - A kill coincident with a level-up is consumed, not carried over.
//   Saturation
//     - At speed_level==MAX_LEVEL, no further increments and no level_up.
//     - sec_cnt and kill_cnt are held at 0.
//   PAUSE
//     - Prescaler, sec_cnt, kill_cnt and speed_level frozen.
//     - kill ignored; playing=0.
//   OVER
//     - speed_level holds its final value; counters frozen; kill and pause ignored.
//   Priority
//     - Within a cycle: resetn > game_over > pause > kill/strobe.
//     - game_over and a threshold hit in the same cycle: OVER wins, no increment.
//   Widths and outputs
//     - Counters are sized by $clog2 of their parameter, never overflow,
//       and compare with ==.
//     - All outputs are registered; there are no combinational paths from input to output.
// TESTING (TICKS_PER_SEC=4, KILLS_PER_LEVEL=3, SECONDS_PER_LEVEL=2, MAX_LEVEL=3)
//   1 Release reset, start pulse, 3 kill pulses
//       -> level_up pulses once, speed_level=1, playing=1, kill_cnt=0.
//   2 Run with no kills
//       -> level_up exactly 8 cycles after entering RUN, and every 8 cycles after
//          until speed_level=3; then no pulses for 100 cycles.
//   3 2 kills, then a 3rd kill on the same cycle as the 2nd strobe
//       -> one level_up, speed_level+1, both counters 0.
//   4 pause=1 for 20 cycles mid-level with 2 kills
//       -> counters and speed_level unchanged, kills ignored;
//          after release, the original remaining time to level-up is preserved.
//   5 game_over at speed_level=2, then a start pulse
//       -> speed_level holds 2 while in OVER; after start, speed_level=0, playing=1.
//   6 resetn=0 asynchronously mid-RUN at speed_level=2
//       -> speed_level=0, playing=0, state IDLE before the next clock edge.

Source files
------------

// File: rtl/asteroid_speed_ramp.sv
`default_nettype none
// ============================================================================
// asteroid_speed_ramp : kill/time driven difficulty ramp for the game clock
// Revision 1.0
// ============================================================================
module asteroid_speed_ramp #(
  parameter int unsigned MAX_LEVEL         = 10,
  parameter int unsigned KILLS_PER_LEVEL   = 8,
  parameter int unsigned SECONDS_PER_LEVEL = 30,
  parameter int unsigned TICKS_PER_SEC     = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic       kill,
  output logic [3:0] speed_level,
  output logic       level_up,
  output logic       playing
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1)     ? $clog2(TICKS_PER_SEC)     : 1;
  localparam int unsigned SW = (SECONDS_PER_LEVEL > 1) ? $clog2(SECONDS_PER_LEVEL) : 1;
  localparam int unsigned KW = (KILLS_PER_LEVEL > 1)   ? $clog2(KILLS_PER_LEVEL)   : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;
  logic [SW-1:0] sec_cnt;
  logic [KW-1:0] kill_cnt;
  logic          advance;
  logic          restart;
  logic          strobe;
  logic          at_max;
  logic          kill_hit;
  logic          sec_hit;
  logic          bump;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (game_over) state_next = OVER;
               else if (pause) state_next = PAUSE;
      PAUSE:   if (game_over) state_next = OVER;
               else if (!pause) state_next = RUN;
      OVER:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase

    // Counting only happens in RUN when neither higher-priority input is active
    advance  = (state == RUN) && !game_over && !pause;
    restart  = ((state == IDLE) || (state == OVER)) && start;
    strobe   = advance && (32'(prescaler) == TICKS_PER_SEC - 1);
    kill_hit = (32'(kill_cnt) + 32'(kill)) == KILLS_PER_LEVEL;
    sec_hit  = (32'(sec_cnt) + 32'(strobe)) == SECONDS_PER_LEVEL;
    at_max   = (speed_level == 4'(MAX_LEVEL));
    bump     = advance && !at_max && (kill_hit || sec_hit);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      prescaler   <= '0;
      sec_cnt     <= '0;
      kill_cnt    <= '0;
      speed_level <= 4'd0;
      level_up    <= 1'b0;
      playing     <= 1'b0;
    end else begin
      level_up <= 1'b0;
      playing  <= (state_next == RUN);
      if (restart) begin
        prescaler   <= '0;
        sec_cnt     <= '0;
        kill_cnt    <= '0;
        speed_level <= 4'd0;
      end else if (advance) begin
        prescaler <= strobe ? '0 : prescaler + PW'(1);
        if (at_max) begin
          sec_cnt  <= '0;
          kill_cnt <= '0;
        end else if (bump) begin
          // A coincident kill or strobe is consumed by the level-up
          speed_level <= speed_level + 4'd1;
          level_up    <= 1'b1;
          sec_cnt     <= '0;
          kill_cnt    <= '0;
        end else begin
          sec_cnt  <= sec_cnt + SW'(strobe);
          kill_cnt <= kill_cnt + KW'(kill);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_asteroid_speed_ramp.sv
`default_nettype none
// ============================================================================
// tb_asteroid_speed_ramp : directed + random bench with a behavioural model
// Revision 1.0
// ============================================================================
module tb_asteroid_speed_ramp;

  localparam int unsigned TPS  = 4;
  localparam int unsigned KPL  = 3;
  localparam int unsigned SPL  = 2;
  localparam int unsigned MAXL = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic       game_over = 1'b0;
  logic       kill     = 1'b0;
  logic [3:0] speed_level;
  logic       level_up;
  logic       playing;

  asteroid_speed_ramp #(
    .MAX_LEVEL        (MAXL),
    .KILLS_PER_LEVEL  (KPL),
    .SECONDS_PER_LEVEL(SPL),
    .TICKS_PER_SEC    (TPS)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .pause      (pause),
    .game_over  (game_over),
    .kill       (kill),
    .speed_level(speed_level),
    .level_up   (level_up),
    .playing    (playing)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;

  // Model state: play mode, level, kills/seconds in level, active cycles since start
  int m_mode, m_level, m_kills, m_secs, m_active;
  bit m_lu;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_level = 0; m_kills = 0; m_secs = 0; m_active = 0; m_lu = 0;
  endtask

  task automatic model_step();
    bit sec_tick;
    m_lu = 0;
    if ((m_mode == M_IDLE || m_mode == M_OVER) && start) begin
      m_mode = M_RUN; m_level = 0; m_kills = 0; m_secs = 0; m_active = 0;
    end else begin
      if (m_mode == M_RUN && !game_over && !pause) begin
        m_active++;
        sec_tick = (m_active % TPS) == 0;
        if (m_level == int'(MAXL)) begin
          m_kills = 0; m_secs = 0;
        end else if (m_kills + int'(kill) == int'(KPL) ||
                     m_secs + int'(sec_tick) == int'(SPL)) begin
          m_level++; m_lu = 1; m_kills = 0; m_secs = 0;
        end else begin
          m_kills += int'(kill); m_secs += int'(sec_tick);
        end
      end
      if (m_mode == M_RUN || m_mode == M_PAUSE) begin
        if (game_over)                        m_mode = M_OVER;
        else if (pause)                       m_mode = M_PAUSE;
        else                                  m_mode = M_RUN;
      end
    end
  endtask

  task automatic compare_all();
    check_val("speed_level", 32'(speed_level), 32'(m_level));
    check_val("level_up", 32'(level_up), 32'(m_lu));
    check_val("playing", 32'(playing), 32'(m_mode == M_RUN));
    check_val("kill_cnt", 32'(dut.kill_cnt), 32'(m_kills));
    check_val("sec_cnt", 32'(dut.sec_cnt), 32'(m_secs));
  endtask

  task automatic cycle(input bit s, input bit p, input bit g, input bit k);
    start = s; pause = p; game_over = g; kill = k;
    @(posedge CLOCK_50);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic restart_game();
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
  endtask

  initial begin
    int first;
    int pulses;
    bit p;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    compare_all();
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // 1: three kills give one level-up
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1);
    check_val("s1_level", 32'(speed_level), 32'd1);
    check_val("s1_pulse", 32'(level_up), 32'd1);
    check_val("s1_playing", 32'(playing), 32'd1);
    check_val("s1_kills", 32'(dut.kill_cnt), 32'd0);
    cycle(0, 0, 0, 0);

    // 2: time-only ramp up to saturation
    restart_game();
    first = 0; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(0, 0, 0, 0);
      if (level_up) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check_val("s2_first", 32'(first), 32'd8);
    check_val("s2_pulses", 32'(pulses), 32'd3);
    check_val("s2_level", 32'(speed_level), 32'd3);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, 0, i % 3 == 0);
      if (level_up) pulses++;
    end
    check_val("s2_sat_pulses", 32'(pulses), 32'd0);

    // 3: third kill coincides with second strobe
    restart_game();
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check_val("s3_pulse", 32'(level_up), 32'd1);
    check_val("s3_level", 32'(speed_level), 32'd1);
    check_val("s3_secs", 32'(dut.sec_cnt), 32'd0);
    cycle(0, 0, 0, 0);
    check_val("s3_single", 32'(level_up), 32'd0);

    // 4: pause preserves the remaining time
    restart_game();
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1); cycle(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, (i == 5) || (i == 11));
    check_val("s4_kills", 32'(dut.kill_cnt), 32'd2);
    check_val("s4_level", 32'(speed_level), 32'd0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 0, 0, 0);
      if (level_up && first == 0) first = i;
    end
    check_val("s4_resume", 32'(first), 32'd6);

    // 5: game over holds level, start clears it
    restart_game();
    repeat (6) cycle(0, 0, 0, 1);
    check_val("s5_level", 32'(speed_level), 32'd2);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, i[0], 0, 1);
    check_val("s5_over_level", 32'(speed_level), 32'd2);
    check_val("s5_over_play", 32'(playing), 32'd0);
    cycle(1, 0, 0, 0);
    check_val("s5_new_level", 32'(speed_level), 32'd0);
    check_val("s5_new_play", 32'(playing), 32'd1);

    // 6: asynchronous reset mid-run
    restart_game();
    repeat (6) cycle(0, 0, 0, 1);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_val("s6_level", 32'(speed_level), 32'd0);
    check_val("s6_play", 32'(playing), 32'd0);
    check_val("s6_state", 32'(dut.state), 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    cycle(0, 0, 0, 1);

    // Random traffic against the model
    p = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 20) == 0) p = ~p;
      cycle($urandom_range(0, 30) == 0, p, $urandom_range(0, 80) == 0,
            $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
